// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO target with a small paged register file (88E1512-style).
// MDC/MDIO are oversampled on clock; all protocol work happens on a detected MDC rise.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter logic [15:0] PHY_ID1      = 16'h0141,
  parameter logic [15:0] PHY_ID2      = 16'h0DD0,
  parameter int unsigned PREAMBLE_MIN = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mdc_in,
  input  logic       mdio_in,
  output logic       mdio_out,
  output logic       mdio_oe,
  output logic [2:0] mode,
  output logic       soft_reset,
  output logic       frame_done,
  output logic [7:0] page
);

  localparam logic [5:0] PRE_MIN   = 6'(PREAMBLE_MIN);
  localparam logic [4:0] REG_ID1   = 5'd2;
  localparam logic [4:0] REG_ID2   = 5'd3;
  localparam logic [4:0] REG_MODE  = 5'd20;
  localparam logic [4:0] REG_PAGE  = 5'd22;
  localparam logic [7:0] PAGE_MODE = 8'd18;

  typedef enum logic [2:0] {
    S_IDLE, S_START2, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
  } state_t;

  logic        mdc_s1, mdc_s2, mdc_d;
  logic        mdio_s1, mdio_s2;
  logic        rise, bit_in;

  state_t      state, state_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [5:0]  pre_cnt, pre_cnt_n;

  logic        op_first;
  logic        is_read;
  logic        ignore;
  logic [3:0]  phy_sh;
  logic [4:0]  reg_q;
  logic [14:0] wr_sh;
  logic [15:0] rd_sh;
  logic [15:0] rd_data;
  logic [15:0] wdata;

  logic [15:0] p0_mem [32];
  logic [14:0] mode_q;

  // Synchronisers reset high so a reset release with MDC held high is not seen as a rise
  always_ff @(posedge clock) begin
    if (reset) begin
      mdc_s1  <= 1'b1;
      mdc_s2  <= 1'b1;
      mdc_d   <= 1'b1;
      mdio_s1 <= 1'b1;
      mdio_s2 <= 1'b1;
    end else begin
      mdc_s1  <= mdc_in;
      mdc_s2  <= mdc_s1;
      mdc_d   <= mdc_s2;
      mdio_s1 <= mdio_in;
      mdio_s2 <= mdio_s1;
    end
  end

  assign rise   = mdc_s2 & ~mdc_d;
  assign bit_in = mdio_s2;
  assign wdata  = {wr_sh, bit_in};
  assign mode   = mode_q[2:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      pre_cnt <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      pre_cnt <= pre_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    pre_cnt_n = pre_cnt;
    if (rise) begin
      case (state)
        S_IDLE: begin
          if (bit_in) begin
            if (pre_cnt != 6'd63) pre_cnt_n = pre_cnt + 6'd1;
          end else begin
            pre_cnt_n = '0;
            if (pre_cnt >= PRE_MIN) state_n = S_START2;
          end
        end
        S_START2: begin
          bit_cnt_n = '0;
          state_n   = bit_in ? S_OP : S_IDLE;
        end
        S_OP: begin
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd1) begin
            bit_cnt_n = '0;
            state_n   = S_PHYAD;
          end
        end
        S_PHYAD: begin
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd4) begin
            bit_cnt_n = '0;
            state_n   = S_REGAD;
          end
        end
        S_REGAD: begin
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd4) begin
            bit_cnt_n = '0;
            state_n   = S_TA;
          end
        end
        S_TA: begin
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd1) begin
            bit_cnt_n = '0;
            state_n   = S_DATA;
          end
        end
        S_DATA: begin
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) begin
            bit_cnt_n = '0;
            state_n   = S_IDLE;
          end
        end
        default: begin
          bit_cnt_n = '0;
          pre_cnt_n = '0;
          state_n   = S_IDLE;
        end
      endcase
    end
  end

  // Read data is taken from the page as it stands before the frame completes
  always_comb begin
    rd_data = '0;
    if (reg_q == REG_PAGE) begin
      rd_data = {8'h00, page};
    end else if (page == 8'd0) begin
      if (reg_q == REG_ID1)      rd_data = PHY_ID1;
      else if (reg_q == REG_ID2) rd_data = PHY_ID2;
      else                       rd_data = p0_mem[reg_q];
    end else if ((page == PAGE_MODE) && (reg_q == REG_MODE)) begin
      rd_data = {1'b0, mode_q};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_first   <= 1'b0;
      is_read    <= 1'b0;
      ignore     <= 1'b0;
      phy_sh     <= '0;
      reg_q      <= '0;
      wr_sh      <= '0;
      rd_sh      <= '0;
      mdio_oe    <= 1'b0;
      mdio_out   <= 1'b1;
      soft_reset <= 1'b0;
      frame_done <= 1'b0;
      page       <= '0;
      mode_q     <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        p0_mem[i] <= (i == 0) ? 16'h1140 : '0;
      end
    end else begin
      soft_reset <= 1'b0;
      frame_done <= 1'b0;
      if (rise) begin
        case (state)
          S_START2: ignore <= 1'b0;
          S_OP: begin
            op_first <= bit_in;
            if (bit_cnt == 5'd1) begin
              is_read <= op_first & ~bit_in;
              if (op_first == bit_in) ignore <= 1'b1;
            end
          end
          S_PHYAD: begin
            phy_sh <= {phy_sh[2:0], bit_in};
            if ((bit_cnt == 5'd4) && ({phy_sh, bit_in} != PHY_ADDR)) ignore <= 1'b1;
          end
          S_REGAD: reg_q <= {reg_q[3:0], bit_in};
          S_TA: begin
            if ((bit_cnt == 5'd0) && is_read && !ignore) begin
              rd_sh    <= rd_data;
              mdio_oe  <= 1'b1;
              mdio_out <= 1'b0;
            end else if ((bit_cnt == 5'd1) && mdio_oe) begin
              mdio_out <= rd_sh[15];
              rd_sh    <= {rd_sh[14:0], 1'b0};
            end
          end
          S_DATA: begin
            wr_sh <= wdata[14:0];
            if (bit_cnt == 5'd15) begin
              mdio_oe  <= 1'b0;
              mdio_out <= 1'b1;
              if (!ignore) begin
                frame_done <= 1'b1;
                if (!is_read) begin
                  if (reg_q == REG_PAGE) begin
                    page <= wdata[7:0];
                  end else if (page == 8'd0) begin
                    if ((reg_q != REG_ID1) && (reg_q != REG_ID2)) p0_mem[reg_q] <= wdata;
                  end else if ((page == PAGE_MODE) && (reg_q == REG_MODE)) begin
                    mode_q     <= wdata[14:0];
                    soft_reset <= wdata[15];
                  end
                end
              end
            end else if (mdio_oe) begin
              mdio_out <= rd_sh[15];
              rd_sh    <= {rd_sh[14:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: an MDIO master drives frames bit by bit; results are
// compared with a vector table, hand sequences and a register-map reference model.
`timescale 1ns/1ps
module tb_mdio_phy_responder;

  localparam int HALF = 8;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mdc_in = 1'b0;
  logic       master_en = 1'b1;
  logic       master_drv = 1'b1;
  logic       mdio_in;
  logic       mdio_out, mdio_oe, soft_reset, frame_done;
  logic [2:0] mode;
  logic [7:0] page;

  // Open-drain style line with pull-up; the target wins while it drives
  assign mdio_in = mdio_oe ? mdio_out : (master_en ? master_drv : 1'b1);

  always #5 clock = ~clock;

  mdio_phy_responder #(
    .PHY_ADDR    (5'd0),
    .PHY_ID1     (16'h0141),
    .PHY_ID2     (16'h0DD0),
    .PREAMBLE_MIN(32)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mdc_in    (mdc_in),
    .mdio_in   (mdio_in),
    .mdio_out  (mdio_out),
    .mdio_oe   (mdio_oe),
    .mode      (mode),
    .soft_reset(soft_reset),
    .frame_done(frame_done),
    .page      (page)
  );

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int sr_cnt = 0;

  always @(negedge clock) begin
    if (frame_done) fd_cnt++;
    if (soft_reset) sr_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference register map
  logic [15:0] m_p0 [32];
  logic [7:0]  m_page;
  logic [14:0] m_r20;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_p0[i] = 16'h0000;
    m_p0[0] = 16'h1140;
    m_page  = 8'h00;
    m_r20   = 15'h0000;
  endtask

  function automatic logic [15:0] m_read(input logic [4:0] rg);
    if (rg == 5'd22) return {8'h00, m_page};
    if (m_page == 8'd0) begin
      if (rg == 5'd2) return 16'h0141;
      if (rg == 5'd3) return 16'h0DD0;
      return m_p0[rg];
    end
    if (m_page == 8'd18 && rg == 5'd20) return {1'b0, m_r20};
    return 16'h0000;
  endfunction

  // Returns 1 when the write should raise soft_reset
  function automatic logic m_write(input logic [4:0] rg, input logic [15:0] d);
    if (rg == 5'd22) begin
      m_page = d[7:0];
    end else if (m_page == 8'd0) begin
      if (rg != 5'd2 && rg != 5'd3) m_p0[rg] = d;
    end else if (m_page == 8'd18 && rg == 5'd20) begin
      m_r20 = d[14:0];
      return d[15];
    end
    return 1'b0;
  endfunction

  // One MDC period; o2/o3 are mdio_oe two and three clocks after the pin rise
  task automatic mdc_bit(input logic b, input logic rel, output logic smp,
                         output logic o2, output logic o3);
    master_en  = !rel;
    master_drv = b;
    repeat (HALF) @(negedge clock);
    mdc_in = 1'b1;
    smp = mdio_in;
    @(negedge clock);
    @(negedge clock);
    o2 = mdio_oe;
    @(negedge clock);
    o3 = mdio_oe;
    repeat (HALF - 3) @(negedge clock);
    mdc_in = 1'b0;
  endtask

  task automatic do_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] rg, input logic [15:0] wd, input int ndata,
                          output logic [15:0] rd, output logic lat_on, output logic lat_off);
    logic s, o2, o3;
    logic [15:0] hdr;
    rd = 16'h0000;
    lat_on = 1'b0;
    lat_off = 1'b0;
    mdc_bit(1'b0, 1'b0, s, o2, o3);
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, 1'b0, s, o2, o3);
    hdr = {2'b01, op, phy, rg, 2'b00};
    for (int i = 15; i >= 2; i--) mdc_bit(hdr[i], 1'b0, s, o2, o3);
    if (op == OP_RD) begin
      mdc_bit(1'b1, 1'b1, s, o2, o3);
      lat_on = !o2 && o3;
      mdc_bit(1'b1, 1'b1, s, o2, o3);
      for (int i = 0; i < ndata; i++) begin
        mdc_bit(1'b1, 1'b1, s, o2, o3);
        rd = {rd[14:0], s};
        if (i == 15) lat_off = o2 && !o3;
      end
    end else begin
      mdc_bit(1'b1, 1'b0, s, o2, o3);
      mdc_bit(1'b0, 1'b0, s, o2, o3);
      for (int i = 0; i < ndata; i++) mdc_bit(wd[15 - i], 1'b0, s, o2, o3);
    end
    master_en  = 1'b1;
    master_drv = 1'b1;
  endtask

  typedef struct {
    int          pre;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wd;
    logic        fd;
    logic [15:0] rd;
    logic [2:0]  md;
    logic [7:0]  pg;
    int          sr;
  } vec_t;

  function automatic vec_t mk(int pre, logic [1:0] op, logic [4:0] phy, logic [4:0] rg,
                              logic [15:0] wd, logic fd, logic [15:0] rd,
                              logic [2:0] md, logic [7:0] pg, int sr);
    vec_t v;
    v.pre = pre; v.op = op; v.phy = phy; v.rg = rg; v.wd = wd;
    v.fd = fd; v.rd = rd; v.md = md; v.pg = pg; v.sr = sr;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [15:0] rd;
    logic        lon, loff, acc, exp_sr, sr_flag;
    int          fd0, sr0, pre;
    logic [1:0]  op;
    logic [4:0]  phy, rg;
    logic [15:0] wd, exp_rd;
    logic [4:0]  regs [8];
    int          pres [5];

    tbl.push_back(mk(32, OP_RD, 5'd0, 5'd3,  16'h0000, 1, 16'h0DD0, 3'd0, 8'h00, 0));
    tbl.push_back(mk(32, OP_WR, 5'd0, 5'd22, 16'h0012, 1, 16'h0000, 3'd0, 8'h12, 0));
    tbl.push_back(mk(32, OP_WR, 5'd0, 5'd20, 16'h0201, 1, 16'h0000, 3'd1, 8'h12, 0));
    tbl.push_back(mk(32, OP_WR, 5'd0, 5'd20, 16'h8201, 1, 16'h0000, 3'd1, 8'h12, 1));
    tbl.push_back(mk(32, OP_RD, 5'd0, 5'd20, 16'h0000, 1, 16'h0201, 3'd1, 8'h12, 0));
    tbl.push_back(mk(32, OP_RD, 5'd3, 5'd20, 16'h0000, 0, 16'hFFFF, 3'd1, 8'h12, 0));
    tbl.push_back(mk(32, OP_RD, 5'd0, 5'd22, 16'h0000, 1, 16'h0012, 3'd1, 8'h12, 0));
    tbl.push_back(mk(32, OP_WR, 5'd3, 5'd22, 16'h0000, 0, 16'h0000, 3'd1, 8'h12, 0));
    tbl.push_back(mk(32, OP_WR, 5'd0, 5'd22, 16'hFF00, 1, 16'h0000, 3'd1, 8'h00, 0));
    tbl.push_back(mk(32, OP_WR, 5'd0, 5'd3,  16'hFFFF, 1, 16'h0000, 3'd1, 8'h00, 0));
    tbl.push_back(mk(32, OP_RD, 5'd0, 5'd3,  16'h0000, 1, 16'h0DD0, 3'd1, 8'h00, 0));
    tbl.push_back(mk(32, OP_WR, 5'd0, 5'd4,  16'hA5A5, 1, 16'h0000, 3'd1, 8'h00, 0));
    tbl.push_back(mk(32, OP_RD, 5'd0, 5'd4,  16'h0000, 1, 16'hA5A5, 3'd1, 8'h00, 0));
    tbl.push_back(mk(20, OP_RD, 5'd0, 5'd4,  16'h0000, 0, 16'hFFFF, 3'd1, 8'h00, 0));
    tbl.push_back(mk(32, OP_RD, 5'd0, 5'd4,  16'h0000, 1, 16'hA5A5, 3'd1, 8'h00, 0));
    tbl.push_back(mk(32, OP_RD, 5'd0, 5'd0,  16'h0000, 1, 16'h1140, 3'd1, 8'h00, 0));
    tbl.push_back(mk(32, OP_RD, 5'd0, 5'd2,  16'h0000, 1, 16'h0141, 3'd1, 8'h00, 0));
    tbl.push_back(mk(32, 2'b00, 5'd0, 5'd4,  16'h1234, 0, 16'h0000, 3'd1, 8'h00, 0));
    tbl.push_back(mk(32, 2'b11, 5'd0, 5'd4,  16'h5678, 0, 16'h0000, 3'd1, 8'h00, 0));
    tbl.push_back(mk(31, OP_WR, 5'd0, 5'd4,  16'h0F0F, 0, 16'h0000, 3'd1, 8'h00, 0));
    tbl.push_back(mk(32, OP_RD, 5'd0, 5'd4,  16'h0000, 1, 16'hA5A5, 3'd1, 8'h00, 0));
    tbl.push_back(mk(40, OP_WR, 5'd0, 5'd22, 16'h0005, 1, 16'h0000, 3'd1, 8'h05, 0));
    tbl.push_back(mk(32, OP_RD, 5'd0, 5'd4,  16'h0000, 1, 16'h0000, 3'd1, 8'h05, 0));
    tbl.push_back(mk(63, OP_WR, 5'd0, 5'd20, 16'hFFFF, 1, 16'h0000, 3'd1, 8'h05, 0));
    tbl.push_back(mk(70, OP_WR, 5'd0, 5'd22, 16'h0012, 1, 16'h0000, 3'd1, 8'h12, 0));
    tbl.push_back(mk(32, OP_RD, 5'd0, 5'd20, 16'h0000, 1, 16'h0201, 3'd1, 8'h12, 0));

    m_reset();
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_oe", {31'd0, mdio_oe}, 32'd0);
    check("reset_out", {31'd0, mdio_out}, 32'd1);
    check("reset_mode", {29'd0, mode}, 32'd0);
    check("reset_page", {24'd0, page}, 32'd0);
    check("reset_sr_fd", {30'd0, soft_reset, frame_done}, 32'd0);

    // Directed vector table
    foreach (tbl[k]) begin
      fd0 = fd_cnt;
      sr0 = sr_cnt;
      do_frame(tbl[k].pre, tbl[k].op, tbl[k].phy, tbl[k].rg, tbl[k].wd, 16, rd, lon, loff);
      check($sformatf("v%0d_frame_done", k), fd_cnt - fd0, {31'd0, tbl[k].fd});
      if (tbl[k].op == OP_RD) begin
        check($sformatf("v%0d_rdata", k), {16'd0, rd}, {16'd0, tbl[k].rd});
        check($sformatf("v%0d_oe_on_3clk", k), {31'd0, lon}, {31'd0, tbl[k].fd});
        check($sformatf("v%0d_oe_off_3clk", k), {31'd0, loff}, {31'd0, tbl[k].fd});
      end
      check($sformatf("v%0d_mode", k), {29'd0, mode}, {29'd0, tbl[k].md});
      check($sformatf("v%0d_page", k), {24'd0, page}, {24'd0, tbl[k].pg});
      check($sformatf("v%0d_soft_reset", k), sr_cnt - sr0, tbl[k].sr);
      if (tbl[k].fd && tbl[k].op == OP_WR) sr_flag = m_write(tbl[k].rg, tbl[k].wd);
    end

    // Reset in the middle of a read, with MDC stalled first
    exp_rd = m_read(5'd20);
    do_frame(32, OP_RD, 5'd0, 5'd20, 16'h0000, 8, rd, lon, loff);
    check("abort_partial_rdata", {24'd0, rd[7:0]}, {24'd0, exp_rd[15:8]});
    repeat (100) @(negedge clock);
    check("stall_oe_held", {31'd0, mdio_oe}, 32'd1);
    check("stall_out_held", {31'd0, mdio_out}, {31'd0, exp_rd[7]});
    reset = 1'b1;
    @(negedge clock);
    check("midreset_oe", {31'd0, mdio_oe}, 32'd0);
    check("midreset_mode", {29'd0, mode}, 32'd0);
    check("midreset_page", {24'd0, page}, 32'd0);
    reset = 1'b0;
    m_reset();
    @(negedge clock);
    fd0 = fd_cnt;
    do_frame(32, OP_RD, 5'd0, 5'd0, 16'h0000, 16, rd, lon, loff);
    check("post_reset_reg0", {16'd0, rd}, 32'h1140);
    check("post_reset_fd", fd_cnt - fd0, 32'd1);
    do_frame(32, OP_RD, 5'd0, 5'd4, 16'h0000, 16, rd, lon, loff);
    check("post_reset_reg4", {16'd0, rd}, 32'h0000);

    // Randomised frames against the reference model
    regs = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd20, 5'd22, 5'd31};
    pres = '{20, 31, 32, 33, 45};
    for (int n = 0; n < 16; n++) begin
      pre = pres[$urandom_range(0, 4)];
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = OP_RD;
        4, 5, 6, 7, 8: op = OP_WR;
        default: op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      endcase
      phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      rg  = regs[$urandom_range(0, 7)];
      wd  = 16'($urandom);
      if (rg == 5'd22) wd[7:0] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'd18;
      acc = (pre >= 32) && (op == OP_RD || op == OP_WR) && (phy == 5'd0);
      exp_rd = (acc && op == OP_RD) ? m_read(rg) : 16'hFFFF;
      exp_sr = 1'b0;
      if (acc && op == OP_WR) exp_sr = m_write(rg, wd);
      fd0 = fd_cnt;
      sr0 = sr_cnt;
      do_frame(pre, op, phy, rg, wd, 16, rd, lon, loff);
      check($sformatf("r%0d_frame_done", n), fd_cnt - fd0, {31'd0, acc});
      if (op == OP_RD) begin
        check($sformatf("r%0d_rdata", n), {16'd0, rd}, {16'd0, exp_rd});
        check($sformatf("r%0d_oe_on_3clk", n), {31'd0, lon}, {31'd0, acc});
      end
      check($sformatf("r%0d_soft_reset", n), sr_cnt - sr0, {31'd0, exp_sr});
      check($sformatf("r%0d_mode", n), {29'd0, mode}, {29'd0, m_r20[2:0]});
      check($sformatf("r%0d_page", n), {24'd0, page}, {24'd0, m_page});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
